fp_sum_arbiter: RTL and testbench
=================================

Name: fp_sum_arbiter

Overview:
Round-robin scheduler that shares one combinational FP summator (comb_fp_summator, float_point_num operands) among NUM_REQ requesters.
- Each requester offers an operand pair over a valid/ready handshake.
- The block grants one requester, latches its operands and drives the shared summator for one cycle.
- It registers the answer and status, then returns them with the requester ID over a valid/ready result channel.
- Sits between the FP-using clients and the single summator instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, $clog2(NUM_REQ), width of requester ID
STATUS_W, 2, width of summator answer_status_o bus

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; synchronous, active-high
req_vld_i  input  NUM_REQ  per-requester operand valid
req_rdy_o  output  NUM_REQ  per-requester accept (one-hot or zero)
req_a_i  input  NUM_REQ x float_point_num  operand A per requester
req_b_i  input  NUM_REQ x float_point_num  operand B per requester
sum_a_o  output  float_point_num  to summator a_i
sum_b_o  output  float_point_num  to summator b_i
sum_vld_o  output  1  to summator vld_i
sum_answer_i  input  float_point_num  from summator answer_o
sum_status_i  input  STATUS_W  from summator answer_status_o
res_vld_o  output  1  result valid
res_rdy_i  input  1  result consumer ready
res_id_o  output  ID_W  requester index owning result
res_answer_o  output  float_point_num  registered sum
res_status_o  output  STATUS_W  registered status
busy_o  output  1  high in CALC or RESP

Behaviour:
Reset (rst_i=1 at posedge) applies regardless of state:
- state=IDLE, rr_ptr=0.
- req_rdy_o=0, sum_vld_o=0, sum_a_o/sum_b_o=0, res_vld_o=0, res_id_o=0, res_answer_o=0, res_status_o=0, busy_o=0.
- An in-flight result is discarded.

FSM states: IDLE, CALC, RESP.

IDLE:
- Combinational round-robin pick over req_vld_i, starting at rr_ptr and wrapping NUM_REQ-1 -> 0.
- If any requester is valid: req_rdy_o[winner]=1 in that cycle (combinational, same cycle as valid).
- At the posedge: latch req_a_i/req_b_i[winner] and winner ID; set rr_ptr = winner+1 mod NUM_REQ; go to CALC.
- If no requester is valid: stay in IDLE and hold rr_ptr.

CALC (exactly 1 cycle):
- sum_vld_o=1; sum_a_o/sum_b_o = latched operands.
- At the posedge: capture sum_answer_i and sum_status_i into res_answer_o/res_status_o, set res_vld_o=1, go to RESP.

RESP:
- res_vld_o=1; res_id_o, res_answer_o and res_status_o stay stable until res_vld_o & res_rdy_i.
- On that handshake: res_vld_o=0 next cycle, go to IDLE.
- req_rdy_o=0 throughout CALC and RESP.

Outside CALC: sum_vld_o=0 and sum_a_o/sum_b_o hold the last latched operands.

Timing:
- Accept to res_vld_o: 2 cycles.
- Minimum issue interval: 3 cycles per operation (IDLE, CALC, RESP with res_rdy_i=1).

Handshake and boundary rules:
- A requester must hold req_vld_i and its operands until it sees req_rdy_o.
- Requester deasserting req_vld_i before grant: no grant, no error.
- Only one req_rdy_o bit is ever high.
- Several requesters valid at once: the first valid at or after rr_ptr wins. Example NUM_REQ=4, rr_ptr=3, valid=4'b1001 -> requester 3 wins, rr_ptr becomes 0.
- Single requester continuously valid: granted every 3 cycles, no starvation.
- res_rdy_i held low: block stalls in RESP and no new grants are issued.

Optional Feature:
FP_SUM_ARB_STATS_EN
- Defined: adds output op_cnt_o [31:0] and input cnt_clr_i.
  - op_cnt_o increments by 1 on each result handshake (res_vld_o & res_rdy_i) and wraps at 2^32-1 -> 0.
  - Reset or cnt_clr_i=1 sets it to 0; clear wins over a simultaneous increment.
- Undefined: the ports and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst_i=1 for 2 cycles with req_vld_i=4'b1111 -> every output is 0, req_rdy_o=0, state IDLE.
- Single op: requester 1 sends a=0x3F600000 (0.875), b=0x400CCCCD (2.2); summator model attached -> req_rdy_o=4'b0010 same cycle; sum_vld_o=1 one cycle later; res_vld_o=1 two cycles after accept with res_id_o=1 and res_answer_o=0x4044CCCD (3.075).
- Fairness: req_vld_i=4'b1111 held, each requester sends 1.0+1.0 (0x3F800000) and res_rdy_i=1 -> grant order 0,1,2,3,0; each res_answer_o=0x40000000; grants 3 cycles apart.
- Backpressure: res_rdy_i=0 for 5 cycles in RESP -> res_* stable, req_rdy_o=0, busy_o=1; res_rdy_i=1 -> IDLE next cycle, then next grant.
- Reset mid-op: assert rst_i during CALC -> next cycle res_vld_o=0, rr_ptr=0, no result is ever delivered for that op.
- Stats (FP_SUM_ARB_STATS_EN): 3 completed ops -> op_cnt_o=3; cnt_clr_i coincident with a 4th handshake -> op_cnt_o=0.

Source files
------------

// File: rtl/fp_sum_arbiter_if.sv
// fp_sum_arbiter_if: requester, summator and result bus of the FP summator arbiter
interface fp_sum_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int STATUS_W = 2,
  parameter int ID_W     = $clog2(NUM_REQ)
);
  typedef logic [31:0] float_point_num;
  logic [NUM_REQ-1:0] req_vld_i;
  logic [NUM_REQ-1:0] req_rdy_o;
  float_point_num [NUM_REQ-1:0] req_a_i;
  float_point_num [NUM_REQ-1:0] req_b_i;
  float_point_num sum_a_o;
  float_point_num sum_b_o;
  logic sum_vld_o;
  float_point_num sum_answer_i;
  logic [STATUS_W-1:0] sum_status_i;
  logic res_vld_o;
  logic res_rdy_i;
  logic [ID_W-1:0] res_id_o;
  float_point_num res_answer_o;
  logic [STATUS_W-1:0] res_status_o;
  modport slave (
    input  req_vld_i, req_a_i, req_b_i, sum_answer_i, sum_status_i, res_rdy_i,
    output req_rdy_o, sum_a_o, sum_b_o, sum_vld_o, res_vld_o, res_id_o, res_answer_o, res_status_o
  );
  modport master (
    output req_vld_i, req_a_i, req_b_i, sum_answer_i, sum_status_i, res_rdy_i,
    input  req_rdy_o, sum_a_o, sum_b_o, sum_vld_o, res_vld_o, res_id_o, res_answer_o, res_status_o
  );
endinterface

// File: rtl/fp_sum_arbiter.sv
// fp_sum_arbiter: round-robin sharing of one FP summator; FP_SUM_ARB_STATS_EN adds op_cnt_o/cnt_clr_i
module fp_sum_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int STATUS_W = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  fp_sum_arbiter_if.slave bus,
`ifdef FP_SUM_ARB_STATS_EN
  input  logic cnt_clr_i,
  output logic [31:0] op_cnt_o,
`endif
  output logic busy_o
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] rr_ptr, win, j;
  logic any;
  always_comb begin
    any = 1'b0;
    win = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_vld_i[j]) begin
        any = 1'b1;
        win = j;
      end
    end
  end
  always_comb begin
    state_nxt = (state == IDLE && any) ? CALC :
                (state == CALC) ? RESP :
                (state == RESP && bus.res_rdy_i) ? IDLE : state;
    bus.req_rdy_o = (state == IDLE && any && !rst_i) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
    bus.sum_vld_o = state == CALC;
    bus.res_vld_o = state == RESP;
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      rr_ptr <= '0;
      bus.sum_a_o <= '0;
      bus.sum_b_o <= '0;
      bus.res_id_o <= '0;
      bus.res_answer_o <= '0;
      bus.res_status_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any) begin
        bus.sum_a_o <= bus.req_a_i[win];
        bus.sum_b_o <= bus.req_b_i[win];
        bus.res_id_o <= win;
        rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      if (state == CALC) begin
        bus.res_answer_o <= bus.sum_answer_i;
        bus.res_status_o <= bus.sum_status_i;
      end
    end
  end
`ifdef FP_SUM_ARB_STATS_EN
  always_ff @(posedge clk_i)
    if (rst_i || cnt_clr_i) op_cnt_o <= '0;
    else if (bus.res_vld_o && bus.res_rdy_i) op_cnt_o <= op_cnt_o + 32'd1;
`endif
endmodule

// File: tb/tb_fp_sum_arbiter.sv
// tb_fp_sum_arbiter: random and directed scoreboard bench with an attached float summator model
module tb_fp_sum_arbiter;
  localparam int N = 4, IW = 2, SW = 2;
  typedef struct {int id; logic [31:0] ans; logic [1:0] st;} res_t;
  logic clk = 0, rst = 1;
  logic busy;
  always #5 clk = ~clk;
  fp_sum_arbiter_if #(.NUM_REQ(N), .STATUS_W(SW)) bus();
`ifdef FP_SUM_ARB_STATS_EN
  logic clr = 0;
  logic [31:0] op_cnt;
  bit clr_rand = 0;
  fp_sum_arbiter #(.NUM_REQ(N), .ID_W(IW), .STATUS_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .cnt_clr_i(clr), .op_cnt_o(op_cnt), .busy_o(busy));
`else
  fp_sum_arbiter #(.NUM_REQ(N), .ID_W(IW), .STATUS_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy));
`endif
  int tests = 0, fails = 0, cyc = 0;
  bit pending = 0;
  int t_acc = 0, ptr = 0, m_ops = 0, last_id = -1;
  logic [31:0] pa, pb, last_ans;
  logic [N-1:0] taken = '0;
  res_t q[$];
  int glog[$], tlog[$];
  int vld_pct = 0, rdy_pct = 100;
  bit fixed = 0, drop = 0;
  logic [31:0] fa, fb;
  logic [N-1:0] mask = '1;
  function automatic real f2r(logic [31:0] f);
    if (f[30:0] == 0) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0});
  endfunction
  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [62:0] m;
    int e;
    d = $realtobits(r);
    if (d[62:0] == 0) return 32'h0;
    m = d[62:0] + 63'h10000000;
    e = int'(m[62:52]) - 896;
    if (e <= 0) return {d[63], 31'b0};
    if (e >= 255) return {d[63], 8'hff, 23'b0};
    return {d[63], 8'(e), m[51:29]};
  endfunction
  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction
  function automatic logic [1:0] fstat(logic [31:0] a, logic [31:0] b);
    return {fadd(a, b) == 32'h0, a[31] ^ b[31]};
  endfunction
  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
  endfunction
  always_comb begin
    bus.sum_answer_i = fadd(bus.sum_a_o, bus.sum_b_o);
    bus.sum_status_i = fstat(bus.sum_a_o, bus.sum_b_o);
  end
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin : model
    logic [N-1:0] er;
    int w;
    bit calc, resp;
    er = '0;
    w = -1;
    if (!pending && !rst)
      for (int k = 0; k < N; k++) if (w < 0 && bus.req_vld_i[(ptr + k) % N]) w = (ptr + k) % N;
    if (w >= 0) er[w] = 1'b1;
    calc = pending && cyc == t_acc + 1;
    resp = pending && cyc >= t_acc + 2;
    chk("req_rdy", bus.req_rdy_o, er);
    chk("sum_vld", bus.sum_vld_o, calc);
    chk("res_vld", bus.res_vld_o, resp);
    chk("busy", busy, pending);
    if (calc) begin
      chk("sum_a", bus.sum_a_o, pa);
      chk("sum_b", bus.sum_b_o, pb);
    end
`ifdef FP_SUM_ARB_STATS_EN
    chk("op_cnt", op_cnt, m_ops);
    if (rst || clr) m_ops = 0;
    else if (resp && bus.res_rdy_i) m_ops++;
`endif
    taken = er;
    if (rst) begin
      pending = 0;
      ptr = 0;
      q.delete();
    end else if (w >= 0) begin
      pending = 1;
      t_acc = cyc;
      ptr = (w + 1) % N;
      pa = bus.req_a_i[w];
      pb = bus.req_b_i[w];
      q.push_back('{w, fadd(pa, pb), fstat(pa, pb)});
      glog.push_back(w);
      tlog.push_back(cyc);
    end else if (resp && bus.res_rdy_i) pending = 0;
  end
  always @(negedge clk) begin : monitor
    if (bus.res_vld_o) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL res_unexpected: got id %0d answer %0h expected no result", bus.res_id_o, bus.res_answer_o);
      end else begin
        chk("res_id", bus.res_id_o, q[0].id);
        chk("res_answer", bus.res_answer_o, q[0].ans);
        chk("res_status", bus.res_status_o, q[0].st);
        if (bus.res_rdy_i) begin
          last_id = q[0].id;
          last_ans = q[0].ans;
          void'(q.pop_front());
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (taken[i] || !bus.req_vld_i[i]) begin
        bus.req_vld_i[i] = mask[i] && ($urandom % 100 < vld_pct);
        bus.req_a_i[i] = fixed ? fa : rnd_fp();
        bus.req_b_i[i] = fixed ? fb : rnd_fp();
      end else if (drop && $urandom % 16 == 0) bus.req_vld_i[i] = 1'b0;
    bus.res_rdy_i = $urandom % 100 < rdy_pct;
`ifdef FP_SUM_ARB_STATS_EN
    clr = clr_rand && $urandom % 8 == 0;
`endif
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    bus.req_vld_i = '0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    bus.req_vld_i = '1;
    bus.req_a_i = '0;
    bus.req_b_i = '0;
    bus.res_rdy_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sum_a", bus.sum_a_o, 0);
    chk("rst_sum_b", bus.sum_b_o, 0);
    chk("rst_res_id", bus.res_id_o, 0);
    chk("rst_res_answer", bus.res_answer_o, 0);
    chk("rst_res_status", bus.res_status_o, 0);
    @(posedge clk);
    #1;
    rst = 0;
    bus.req_vld_i = '0;
    // single operation from requester 1
    bus.req_vld_i[1] = 1;
    bus.req_a_i[1] = 32'h3F600000;
    bus.req_b_i[1] = 32'h400CCCCD;
    repeat (6) step();
    chk("single_id", last_id, 1);
    chk("single_answer", last_ans, 32'h4044CCCD);
    // fairness with all four requesters continuously valid
    do_reset();
    glog.delete();
    tlog.delete();
    fixed = 1;
    fa = 32'h3F800000;
    fb = 32'h3F800000;
    vld_pct = 100;
    bus.req_vld_i = '1;
    bus.req_a_i = {N{fa}};
    bus.req_b_i = {N{fb}};
    repeat (15) step();
    for (int i = 0; i < 5; i++) chk("grant_order", (i < glog.size()) ? glog[i] : -1, i % 4);
    for (int i = 1; i < 5; i++) chk("grant_gap", (i < tlog.size()) ? tlog[i] - tlog[i-1] : -1, 3);
    chk("fair_answer", last_ans, 32'h40000000);
    // backpressure stall in RESP
    rdy_pct = 0;
    repeat (8) step();
    rdy_pct = 100;
    repeat (8) step();
    // reset while in CALC
    for (int i = 0; i < 10; i++) begin
      step();
      if (pending && cyc == t_acc + 1) break;
    end
    rst = 1;
    glog.delete();
    @(posedge clk);
    #1;
    rst = 0;
    repeat (6) step();
    chk("post_rst_grant", (glog.size() > 0) ? glog[0] : -1, 0);
`ifdef FP_SUM_ARB_STATS_EN
    do_reset();
    mask = 4'b0001;
    for (int i = 0; i < 30 && m_ops < 3; i++) step();
    @(negedge clk);
    chk("op_cnt_3", op_cnt, 3);
    rdy_pct = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pending && cyc >= t_acc + 2) break;
    end
    bus.res_rdy_i = 1;
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    @(negedge clk);
    chk("op_cnt_clr_wins", op_cnt, 0);
    rdy_pct = 100;
    mask = '1;
    clr_rand = 1;
`endif
    // randomized traffic with drops, backpressure and random operands
    fixed = 0;
    drop = 1;
    vld_pct = 40;
    rdy_pct = 70;
    repeat (2000) step();
`ifdef FP_SUM_ARB_STATS_EN
    clr_rand = 0;
`endif
    vld_pct = 0;
    drop = 0;
    rdy_pct = 100;
    repeat (20) step();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
